// File: rtl/capture_trig_ctrl_if.sv
// Sample-stream, BRAM write-port and frame-publish handshake signals of the capture sequencer.
// master = sequencer side, slave = ADC stage / BRAM / reader side.
interface capture_trig_ctrl_if #(
  parameter int W  = 14,
  parameter int AW = 10
);
  logic [2*W-1:0] sample_in;
  logic           sample_valid;
  logic           frame_ack;

  logic           wr_en;
  logic [AW:0]    wr_addr;
  logic [2*W-1:0] wr_data;

  logic           frame_ready;
  logic           frame_half;
  logic [AW-1:0]  frame_start;
  logic           frame_auto;

  modport master (
    input  sample_in, sample_valid, frame_ack,
    output wr_en, wr_addr, wr_data,
    output frame_ready, frame_half, frame_start, frame_auto
  );

  modport slave (
    output sample_in, sample_valid, frame_ack,
    input  wr_en, wr_addr, wr_data,
    input  frame_ready, frame_half, frame_start, frame_auto
  );
endinterface

// File: rtl/capture_trig_ctrl.sv
// Trigger/acquisition sequencer for the ADC-side write port of a ping-pong sample BRAM:
// circular pre-trigger fill, hysteresis edge trigger on channel A, post-trigger fill, ready/ack publish.
module capture_trig_ctrl #(
  parameter int W        = 14,
  parameter int AW       = 10,
  parameter int AUTO_CYC = 6000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run_i,
  input  logic [1:0]          mode_i,
  input  logic                trig_edge_i,
  input  logic [W-1:0]        trig_level_i,
  input  logic [W-2:0]        trig_hyst_i,
  input  logic [AW-1:0]       pretrig_len_i,
  capture_trig_ctrl_if.master bus,
  output logic [2:0]          state_o
);
  localparam int              ACW         = (AUTO_CYC > 2) ? $clog2(AUTO_CYC) : 1;
  localparam logic [ACW-1:0]  AUTO_LAST   = ACW'(AUTO_CYC - 1);
  localparam logic [AW:0]     N_FULL      = {1'b1, {AW{1'b0}}};
  localparam logic [1:0]      MODE_AUTO   = 2'd0;
  localparam logic [1:0]      MODE_SINGLE = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             wh_q, wh_d;
  logic [AW-1:0]    off_q, off_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [AW-1:0]    p_q, p_d;
  logic             arm_q, arm_d;
  logic [ACW-1:0]   auto_cnt_q, auto_cnt_d;
  logic [AW-1:0]    cand_q, cand_d;
  logic             autof_q, autof_d;
  logic             run_prev_q;

  logic             wr_en_q, wr_en_d;
  logic [AW:0]      wr_addr_q, wr_addr_d;
  logic [2*W-1:0]   wr_data_q, wr_data_d;
  logic             rdy_q, rdy_d;
  logic             half_q, half_d;
  logic [AW-1:0]    start_q, start_d;
  logic             fauto_q, fauto_d;

  // Threshold arithmetic in W+1 bits so level +/- hysteresis never wraps.
  logic signed [W:0] a_ext, lvl_ext, hyst_ext, lo_thr, hi_thr;
  logic              arm_set, real_trig, forced_trig;
  logic [AW:0]       post_len;
  logic              complete, publish, restart;

  always_comb begin
    a_ext       = $signed({bus.sample_in[W-1], bus.sample_in[W-1:0]});
    lvl_ext     = $signed({trig_level_i[W-1], trig_level_i});
    hyst_ext    = $signed({2'b00, trig_hyst_i});
    lo_thr      = lvl_ext - hyst_ext;
    hi_thr      = lvl_ext + hyst_ext;
    arm_set     = trig_edge_i ? (a_ext > hi_thr) : (a_ext < lo_thr);
    real_trig   = arm_q && (trig_edge_i ? (a_ext <= lvl_ext) : (a_ext >= lvl_ext));
    forced_trig = (mode_i == MODE_AUTO) && (auto_cnt_q == AUTO_LAST);
    post_len    = N_FULL - {1'b0, p_q};
  end

  always_comb begin
    state_d    = state_q;
    wh_d       = wh_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    arm_d      = arm_q;
    auto_cnt_d = auto_cnt_q;
    cand_d     = cand_q;
    autof_d    = autof_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = bus.sample_in;
    rdy_d      = rdy_q & ~bus.frame_ack;
    half_d     = half_q;
    start_d    = start_q;
    fauto_d    = fauto_q;
    complete   = 1'b0;
    publish    = 1'b0;
    restart    = 1'b0;

    if (state_q == ARMED && auto_cnt_q != AUTO_LAST) begin
      auto_cnt_d = auto_cnt_q + ACW'(1);
    end

    if (!run_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (mode_i != MODE_SINGLE || !run_prev_q) restart = 1'b1;
        end
        PRE, ARMED, POST: begin
          if (bus.sample_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wh_q, off_q};
            off_d     = off_q + AW'(1);
            if (state_q != POST && arm_set) arm_d = 1'b1;
            if (state_q == PRE) begin
              cnt_d = cnt_q + (AW+1)'(1);
              if (cnt_d == {1'b0, p_q}) begin
                state_d    = ARMED;
                auto_cnt_d = '0;
              end
            end else if (state_q == ARMED) begin
              if (real_trig || forced_trig) begin
                cand_d  = off_q - p_q;
                autof_d = ~real_trig;
                cnt_d   = (AW+1)'(1);
                state_d = POST;
                if (post_len == (AW+1)'(1)) complete = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + (AW+1)'(1);
              if (cnt_d == post_len) complete = 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.frame_ack) publish = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      // An ack arriving on the completion edge frees the reader side in time to publish.
      if (complete) begin
        if (rdy_q && !bus.frame_ack) state_d = HOLD;
        else                         publish = 1'b1;
      end

      if (publish) begin
        rdy_d   = 1'b1;
        half_d  = wh_q;
        start_d = cand_d;
        fauto_d = autof_d;
        wh_d    = ~wh_q;
        if (mode_i == MODE_SINGLE) state_d = IDLE;
        else                       restart = 1'b1;
      end

      if (restart) begin
        p_d        = pretrig_len_i;
        cnt_d      = '0;
        arm_d      = 1'b0;
        auto_cnt_d = '0;
        state_d    = (pretrig_len_i == '0) ? ARMED : PRE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wh_q       <= 1'b0;
      off_q      <= '0;
      cnt_q      <= '0;
      p_q        <= '0;
      arm_q      <= 1'b0;
      auto_cnt_q <= '0;
      cand_q     <= '0;
      autof_q    <= 1'b0;
      run_prev_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rdy_q      <= 1'b0;
      half_q     <= 1'b0;
      start_q    <= '0;
      fauto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wh_q       <= wh_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      arm_q      <= arm_d;
      auto_cnt_q <= auto_cnt_d;
      cand_q     <= cand_d;
      autof_q    <= autof_d;
      run_prev_q <= run_i;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rdy_q      <= rdy_d;
      half_q     <= half_d;
      start_q    <= start_d;
      fauto_q    <= fauto_d;
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.frame_ready = rdy_q;
  assign bus.frame_half  = half_q;
  assign bus.frame_start = start_q;
  assign bus.frame_auto  = fauto_q;
  assign state_o         = state_q;
endmodule
